// File: rtl/alu_issue_station_pkg.sv
// Shared defaults, ALU opcode encodings and small helpers for the ALU issue station.
package alu_issue_station_pkg;

  localparam int RS_DEPTH_DEF = 4;
  localparam int TAG_W_DEF    = 4;
  localparam int OP_W_DEF     = 5;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_JALR = 5'd5;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_DRAIN = 2'd2,
    SLOT_CLEAR = 2'd3
  } slot_act_e;

  // Isolates the lowest set bit (two's-complement trick); zero in gives zero out.
  function automatic logic [15:0] lowest_set(input logic [15:0] v);
    return v & (~v + 16'd1);
  endfunction

endpackage

// File: rtl/alu_issue_station_age_select.sv
// Age matrix over the station entries; grants the oldest ready entry (one-hot).
module rs_age_select #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic [N-1:0] alloc_oh_i,
  input  logic [N-1:0] free_oh_i,
  input  logic [N-1:0] ready_i,
  output logic [N-1:0] grant_oh_o,
  output logic         any_ready_o
);

  // older_q[i][j] = 1 means entry i was allocated before entry j
  logic [N-1:0][N-1:0] older_q, older_d;
  logic [N-1:0]        older_col_s [N];

  // Next age matrix: a freed row/column is wiped, a new entry is younger than all
  always_comb begin
    older_d = older_q;
    if (flush_i) begin
      older_d = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (free_oh_i[i]) begin
          older_d[i] = '0;
          for (int j = 0; j < N; j++) older_d[j][i] = 1'b0;
        end else begin
          older_d[i] = older_d[i];
        end
      end
      for (int i = 0; i < N; i++) begin
        if (alloc_oh_i[i]) begin
          older_d[i] = '0;
          for (int j = 0; j < N; j++) begin
            if (j != i) older_d[j][i] = 1'b1;
            else        older_d[j][i] = 1'b0;
          end
        end else begin
          older_d[i] = older_d[i];
        end
      end
    end
  end

  // Age matrix register, frozen while the pipeline is stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   older_q <= '0;
    else if (en_i) older_q <= older_d;
  end

  // Transpose so each entry sees which entries are older than it
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) older_col_s[i][j] = older_q[j][i];
    end
  end

  // An entry wins when it is ready and no older entry is ready
  always_comb begin
    for (int i = 0; i < N; i++) begin
      grant_oh_o[i] = ready_i[i] & ~|(ready_i & older_col_s[i]);
    end
  end

  assign any_ready_o = |ready_i;

endmodule

// File: rtl/alu_issue_station.sv
// Reservation station for the shared ALU: holds dispatched ops, snoops the CDB,
// issues the oldest ready op and registers its result in a valid/ready output slot.
module alu_issue_station
  import alu_issue_station_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int OP_W     = OP_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_addr,
  input  logic [31:0]      disp_v1,
  input  logic [31:0]      disp_v2,
  input  logic             disp_q1p,
  input  logic             disp_q2p,
  input  logic [TAG_W-1:0] disp_q1,
  input  logic [TAG_W-1:0] disp_q2,
  input  logic [TAG_W-1:0] disp_dest,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [31:0]      alu_addr,
  input  logic [31:0]      alu_result,
  input  logic             alu_jalr_done,
  input  logic [31:0]      alu_jalr_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_value,
  output logic             out_jalr,
  output logic [31:0]      out_jalr_addr
);

  logic [RS_DEPTH-1:0] valid_q, valid_d, q1p_q, q1p_d, q2p_q, q2p_d;
  logic [OP_W-1:0]     op_q   [RS_DEPTH];
  logic [OP_W-1:0]     op_d   [RS_DEPTH];
  logic [31:0]         addr_q [RS_DEPTH];
  logic [31:0]         addr_d [RS_DEPTH];
  logic [31:0]         v1_q   [RS_DEPTH];
  logic [31:0]         v1_d   [RS_DEPTH];
  logic [31:0]         v2_q   [RS_DEPTH];
  logic [31:0]         v2_d   [RS_DEPTH];
  logic [TAG_W-1:0]    q1_q   [RS_DEPTH];
  logic [TAG_W-1:0]    q1_d   [RS_DEPTH];
  logic [TAG_W-1:0]    q2_q   [RS_DEPTH];
  logic [TAG_W-1:0]    q2_d   [RS_DEPTH];
  logic [TAG_W-1:0]    dest_q [RS_DEPTH];
  logic [TAG_W-1:0]    dest_d [RS_DEPTH];

  logic [RS_DEPTH-1:0] ready_s, alloc_oh_s, grant_s;
  logic                any_ready_s, disp_fire_s, issue_fire_s, byp1_s, byp2_s;

  logic             out_valid_q, out_valid_d, out_jalr_q, out_jalr_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [31:0]      out_value_q, out_value_d, out_jalr_addr_q, out_jalr_addr_d;
  slot_act_e        slot_act_s;

  assign disp_ready   = rdy_in & ~&valid_q;
  assign alloc_oh_s   = RS_DEPTH'(lowest_set(16'(~valid_q)));
  assign ready_s      = valid_q & ~q1p_q & ~q2p_q;
  assign disp_fire_s  = disp_valid & disp_ready & ~flush_in;
  assign issue_fire_s = rdy_in & ~flush_in & any_ready_s & (~out_valid_q | out_ready);
  assign byp1_s       = disp_q1p & cdb_valid & (cdb_tag == disp_q1);
  assign byp2_s       = disp_q2p & cdb_valid & (cdb_tag == disp_q2);

  rs_age_select #(.N(RS_DEPTH)) u_age (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .en_i        (rdy_in),
    .flush_i     (flush_in),
    .alloc_oh_i  ({RS_DEPTH{disp_fire_s}} & alloc_oh_s),
    .free_oh_i   ({RS_DEPTH{issue_fire_s}} & grant_s),
    .ready_i     (ready_s),
    .grant_oh_o  (grant_s),
    .any_ready_o (any_ready_s)
  );

  // Drive the ALU from the granted entry; all zero when nothing is ready
  always_comb begin
    alu_op   = '0;
    alu_op1  = 32'd0;
    alu_op2  = 32'd0;
    alu_addr = 32'd0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      alu_op   = alu_op   | ({OP_W{grant_s[i]}} & op_q[i]);
      alu_op1  = alu_op1  | ({32{grant_s[i]}} & v1_q[i]);
      alu_op2  = alu_op2  | ({32{grant_s[i]}} & v2_q[i]);
      alu_addr = alu_addr | ({32{grant_s[i]}} & addr_q[i]);
    end
  end

  // Entry next state: flush, then allocate, otherwise issue-free and CDB wakeup
  always_comb begin
    valid_d = valid_q;
    q1p_d   = q1p_q;
    q2p_d   = q2p_q;
    op_d    = op_q;
    addr_d  = addr_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    dest_d  = dest_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (flush_in) begin
        valid_d[i] = 1'b0;
      end else if (disp_fire_s && alloc_oh_s[i]) begin
        valid_d[i] = 1'b1;
        op_d[i]    = disp_op;
        addr_d[i]  = disp_addr;
        dest_d[i]  = disp_dest;
        q1_d[i]    = disp_q1;
        q2_d[i]    = disp_q2;
        v1_d[i]    = byp1_s ? cdb_value : disp_v1;
        v2_d[i]    = byp2_s ? cdb_value : disp_v2;
        q1p_d[i]   = disp_q1p & ~byp1_s;
        q2p_d[i]   = disp_q2p & ~byp2_s;
      end else begin
        if (issue_fire_s && grant_s[i]) valid_d[i] = 1'b0;
        else                            valid_d[i] = valid_q[i];
        if (valid_q[i] && q1p_q[i] && cdb_valid && (q1_q[i] == cdb_tag)) begin
          v1_d[i]  = cdb_value;
          q1p_d[i] = 1'b0;
        end else begin
          v1_d[i]  = v1_q[i];
          q1p_d[i] = q1p_q[i];
        end
        if (valid_q[i] && q2p_q[i] && cdb_valid && (q2_q[i] == cdb_tag)) begin
          v2_d[i]  = cdb_value;
          q2p_d[i] = 1'b0;
        end else begin
          v2_d[i]  = v2_q[i];
          q2p_d[i] = q2p_q[i];
        end
      end
    end
  end

  // Entry storage register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
      q1p_q   <= '0;
      q2p_q   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        op_q[i]   <= '0;
        addr_q[i] <= 32'd0;
        v1_q[i]   <= 32'd0;
        v2_q[i]   <= 32'd0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else if (rdy_in) begin
      valid_q <= valid_d;
      q1p_q   <= q1p_d;
      q2p_q   <= q2p_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      dest_q  <= dest_d;
    end
  end

  // Output slot action; a held result blocks issue through issue_fire_s
  always_comb begin
    if (flush_in)                      slot_act_s = SLOT_CLEAR;
    else if (issue_fire_s)             slot_act_s = SLOT_LOAD;
    else if (out_valid_q && out_ready) slot_act_s = SLOT_DRAIN;
    else                               slot_act_s = SLOT_HOLD;
  end

  // Output slot next state
  always_comb begin
    out_valid_d     = out_valid_q;
    out_tag_d       = out_tag_q;
    out_value_d     = out_value_q;
    out_jalr_d      = out_jalr_q;
    out_jalr_addr_d = out_jalr_addr_q;
    case (slot_act_s)
      SLOT_LOAD: begin
        out_valid_d     = 1'b1;
        out_tag_d       = alu_dest_s();
        out_value_d     = alu_result;
        out_jalr_d      = alu_jalr_done;
        out_jalr_addr_d = alu_jalr_addr;
      end
      SLOT_DRAIN, SLOT_CLEAR: out_valid_d = 1'b0;
      SLOT_HOLD:              out_valid_d = out_valid_q;
      default:                out_valid_d = out_valid_q;
    endcase
  end

  // Destination tag of the granted entry
  function automatic logic [TAG_W-1:0] alu_dest_s();
    logic [TAG_W-1:0] t;
    t = '0;
    for (int i = 0; i < RS_DEPTH; i++) t = t | ({TAG_W{grant_s[i]}} & dest_q[i]);
    return t;
  endfunction

  // Output slot register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_valid_q     <= 1'b0;
      out_tag_q       <= '0;
      out_value_q     <= 32'd0;
      out_jalr_q      <= 1'b0;
      out_jalr_addr_q <= 32'd0;
    end else if (rdy_in) begin
      out_valid_q     <= out_valid_d;
      out_tag_q       <= out_tag_d;
      out_value_q     <= out_value_d;
      out_jalr_q      <= out_jalr_d;
      out_jalr_addr_q <= out_jalr_addr_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_tag       = out_tag_q;
  assign out_value     = out_value_q;
  assign out_jalr      = out_jalr_q;
  assign out_jalr_addr = out_jalr_addr_q;

endmodule

// File: tb/tb_alu_issue_station.sv
// Scoreboard bench: an age-ordered queue model predicts each issued result;
// a negedge monitor compares the output slot and handshake flags against it.
`timescale 1ns/1ps
module tb_alu_issue_station;
  import alu_issue_station_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr, v1, v2;
    bit          q1p, q2p;
    logic [3:0]  q1, q2, dest;
  } ent_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
    bit          jalr;
    logic [31:0] jaddr;
  } res_t;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in, disp_valid, disp_ready, disp_q1p, disp_q2p;
  logic [4:0]  disp_op, alu_op;
  logic [31:0] disp_addr, disp_v1, disp_v2, cdb_value;
  logic [3:0]  disp_q1, disp_q2, disp_dest, cdb_tag, out_tag;
  logic        cdb_valid, alu_jalr_done, out_valid, out_ready, out_jalr;
  logic [31:0] alu_op1, alu_op2, alu_addr, alu_result, alu_jalr_addr, out_value, out_jalr_addr;

  ent_t mq[$];
  res_t sb[$];
  bit   m_ov;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [4:0] ops [6];

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] ref_val(input logic [4:0] op, input logic [31:0] a, b, pc);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_JALR: return pc + 32'd4;
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_result    = ref_val(alu_op, alu_op1, alu_op2, alu_addr);
  assign alu_jalr_done = (alu_op == ALU_JALR);
  assign alu_jalr_addr = (alu_op == ALU_JALR) ? alu_op1 + alu_op2 : 32'd0;

  alu_issue_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_addr(disp_addr), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1p(disp_q1p), .disp_q2p(disp_q2p), .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_dest(disp_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_addr(alu_addr),
    .alu_result(alu_result), .alu_jalr_done(alu_jalr_done), .alu_jalr_addr(alu_jalr_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_value(out_value),
    .out_jalr(out_jalr), .out_jalr_addr(out_jalr_addr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: entries kept oldest-first in a queue
  initial begin
    int   pick;
    bit   can_disp;
    ent_t e;
    res_t r;
    forever begin
      @(posedge clk_in or negedge rst_in);
      if (!rst_in) begin
        mq.delete(); sb.delete(); m_ov = 1'b0;
      end else if (rdy_in) begin
        if (flush_in) begin
          mq.delete(); sb.delete(); m_ov = 1'b0;
        end else begin
          can_disp = (mq.size() < DEPTH);
          pick = -1;
          if (!m_ov || out_ready)
            for (int k = 0; k < mq.size(); k++)
              if (pick < 0 && !mq[k].q1p && !mq[k].q2p) pick = k;
          if (pick >= 0) begin
            e = mq[pick];
            r.tag   = e.dest;
            r.val   = ref_val(e.op, e.v1, e.v2, e.addr);
            r.jalr  = (e.op == ALU_JALR);
            r.jaddr = r.jalr ? e.v1 + e.v2 : 32'd0;
            sb.push_back(r);
            mq.delete(pick);
            m_ov = 1'b1;
          end else if (out_ready) begin
            m_ov = 1'b0;
          end
          for (int k = 0; k < mq.size(); k++) begin
            e = mq[k];
            if (cdb_valid && e.q1p && e.q1 == cdb_tag) begin e.v1 = cdb_value; e.q1p = 1'b0; end
            if (cdb_valid && e.q2p && e.q2 == cdb_tag) begin e.v2 = cdb_value; e.q2p = 1'b0; end
            mq[k] = e;
          end
          if (disp_valid && can_disp) begin
            e.op = disp_op; e.addr = disp_addr; e.dest = disp_dest;
            e.q1 = disp_q1; e.q2 = disp_q2;
            e.v1 = disp_v1; e.v2 = disp_v2; e.q1p = disp_q1p; e.q2p = disp_q2p;
            if (cdb_valid && e.q1p && e.q1 == cdb_tag) begin e.v1 = cdb_value; e.q1p = 1'b0; end
            if (cdb_valid && e.q2p && e.q2 == cdb_tag) begin e.v2 = cdb_value; e.q2p = 1'b0; end
            mq.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: flags every cycle, result contents on each accepted handshake
  initial begin
    res_t r;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_value", out_value, 32'd0);
        check("reset_disp_ready", 32'(disp_ready), 32'(rdy_in));
      end else begin
        check("disp_ready", 32'(disp_ready), 32'(rdy_in && (mq.size() < DEPTH)));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (out_valid && out_ready && rdy_in) begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_result: tag %0h value %0h with nothing expected", out_tag, out_value);
          end else begin
            r = sb.pop_front();
            check("out_tag", 32'(out_tag), 32'(r.tag));
            check("out_value", out_value, r.val);
            check("out_jalr", 32'(out_jalr), 32'(r.jalr));
            check("out_jalr_addr", out_jalr_addr, r.jaddr);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] pc, a, b,
                      input logic p1, input logic [3:0] t1, input logic p2, input logic [3:0] t2,
                      input logic [3:0] d);
    disp_op = op; disp_addr = pc; disp_v1 = a; disp_v2 = b;
    disp_q1p = p1; disp_q1 = t1; disp_q2p = p2; disp_q2 = t2; disp_dest = d;
    disp_valid = 1'b1;
    step();
    disp_valid = 1'b0;
  endtask

  initial begin
    ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_JALR};
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; out_ready = 1'b1;
    disp_valid = 1'b0; disp_op = ALU_ADD; disp_addr = 32'd0; disp_v1 = 32'd0; disp_v2 = 32'd0;
    disp_q1p = 1'b0; disp_q2p = 1'b0; disp_q1 = 4'd0; disp_q2 = 4'd0; disp_dest = 4'd0;
    cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_value = 32'd0;
    repeat (3) step();
    rst_in = 1'b1;
    step();

    disp(ALU_ADD, 32'h0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    repeat (4) step();

    disp(ALU_SUB, 32'h0, 32'd0, 32'd3, 1'b1, 4'd9, 1'b0, 4'd0, 4'd1);
    repeat (2) step();
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'd20;
    step();
    cdb_valid = 1'b0;
    repeat (3) step();

    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'd4;
    disp(ALU_ADD, 32'h0, 32'd0, 32'd1, 1'b1, 4'd9, 1'b0, 4'd0, 4'd2);
    cdb_valid = 1'b0;
    repeat (3) step();

    out_ready = 1'b0;
    for (int k = 0; k < 6; k++)
      disp(ALU_ADD, 32'h0, 32'(k * 10), 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'(k + 4));
    repeat (2) step();
    out_ready = 1'b1;
    repeat (8) step();

    disp(ALU_JALR, 32'h40, 32'h100, 32'd8, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    repeat (3) step();

    out_ready = 1'b0;
    disp(ALU_XOR, 32'h0, 32'hF0, 32'h0F, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    disp(ALU_ADD, 32'h0, 32'd1, 32'd1, 1'b1, 4'd12, 1'b0, 4'd0, 4'd9);
    disp(ALU_OR,  32'h0, 32'd1, 32'd2, 1'b0, 4'd0, 1'b1, 4'd13, 4'd10);
    step();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0; out_ready = 1'b1;
    repeat (2) step();

    for (int c = 0; c < 400; c++) begin
      rdy_in     = ($urandom_range(9) != 0);
      flush_in   = ($urandom_range(49) == 0);
      out_ready  = ($urandom_range(9) < 7);
      disp_valid = ($urandom_range(9) < 6);
      disp_op    = ops[$urandom_range(5)];
      disp_addr  = $urandom; disp_v1 = $urandom; disp_v2 = $urandom;
      disp_q1p   = ($urandom_range(9) < 3); disp_q1 = 4'($urandom_range(15));
      disp_q2p   = ($urandom_range(9) < 3); disp_q2 = 4'($urandom_range(15));
      disp_dest  = 4'($urandom_range(15));
      cdb_valid  = ($urandom_range(9) < 4);
      cdb_tag    = 4'($urandom_range(15));
      cdb_value  = $urandom;
      step();
    end

    rdy_in = 1'b1; flush_in = 1'b0; disp_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      cdb_valid = 1'b1; cdb_tag = 4'(t); cdb_value = $urandom;
      step();
    end
    cdb_valid = 1'b0;
    for (int k = 0; k < 100 && (mq.size() != 0 || sb.size() != 0 || out_valid); k++) step();
    check("drain_empty", 32'(mq.size() + sb.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
